// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
// Bundles the two-port request/response channels and the ALU drive/return
// lines of alu_share_arbiter.
//   req_valid/req_ready      per-port request handshake
//   req_op0/1, req_a0/1, req_b0/1   per-port op code and operands
//   rsp_valid/rsp_ready      per-port response handshake
//   rsp_result/v/zero/err    shared response payload
//   alu_op/alu_a/alu_b       arbiter -> ALU
//   alu_result/alu_v         ALU -> arbiter (combinational)
// Modports: slave = the arbiter, master = clients plus the ALU.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2:0]       req_op0;
    logic [2:0]       req_op1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_v;
    logic             rsp_zero;
    logic             rsp_err;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_v;

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        input  rsp_ready, alu_result, alu_v,
        output req_ready, rsp_valid, rsp_result, rsp_v, rsp_zero, rsp_err,
        output alu_op, alu_a, alu_b
    );

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        output rsp_ready, alu_result, alu_v,
        input  req_ready, rsp_valid, rsp_result, rsp_v, rsp_zero, rsp_err,
        input  alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational 32-bit ALU between two clients (port 0: branch/
// address unit, port 1: execute stage). One op in flight at a time:
// IDLE (accept) -> EXEC (ALU driven from latched regs) -> RESP (hold result
// until the owning port accepts).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    alu_share_arbiter_if.slave (request, response and ALU lines)
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  defined: port 0 always wins contention;
//                          undefined: round-robin on a 1-bit 'last' pointer.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_share_arbiter_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [1:0]       stateReg;
    logic [1:0]       stateNext;
    logic             idReg;
    logic [2:0]       opReg;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [WIDTH-1:0] resultReg;
    logic             vReg;
    logic             zeroReg;
    logic             errReg;

    logic             winner;
    logic             handshake;
    logic             opIllegal;
    logic [WIDTH-1:0] resultNext;

    // A request is accepted in the same cycle it is presented, as long as
    // the sequencer is idle.
    assign handshake = (stateReg == IDLE) && (|bus.req_valid);

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign winner = ~bus.req_valid[0];
`else
    logic lastReg;

    // Under contention the port that did not win last time goes next.
    assign winner = (&bus.req_valid) ? ~lastReg : bus.req_valid[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            lastReg <= 1'b1;
        end else if (handshake) begin
            lastReg <= winner;
        end
    end
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign bus.req_ready[gi] = handshake && (winner == 1'(gi));
            assign bus.rsp_valid[gi] = (stateReg == RESP) && (idReg == 1'(gi));
        end
    endgenerate

    always_comb begin
        opIllegal = 1'b1;
        case (opReg)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: opIllegal = 1'b0;
            default:                               opIllegal = 1'b1;
        endcase
    end

    assign resultNext = opIllegal ? '0 : bus.alu_result;

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (handshake) stateNext = EXEC;
            EXEC:    stateNext = RESP;
            RESP:    if (bus.rsp_ready[idReg]) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg  <= IDLE;
            idReg     <= 1'b0;
            opReg     <= OP_AND;
            aReg      <= '0;
            bReg      <= '0;
            resultReg <= '0;
            vReg      <= 1'b0;
            zeroReg   <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            stateReg <= stateNext;
            if (handshake) begin
                idReg <= winner;
                opReg <= winner ? bus.req_op1 : bus.req_op0;
                aReg  <= winner ? bus.req_a1  : bus.req_a0;
                bReg  <= winner ? bus.req_b1  : bus.req_b0;
            end
            if (stateReg == EXEC) begin
                resultReg <= resultNext;
                // The ALU's MSB overflow is only meaningful for add/subtract.
                vReg      <= ((opReg == OP_ADD) || (opReg == OP_SUB)) ? bus.alu_v : 1'b0;
                zeroReg   <= (resultNext == '0);
                errReg    <= opIllegal;
            end
        end
    end

    // Operand lines simply follow the latched registers, so they hold their
    // last values outside EXEC. Illegal codes are never presented to the ALU.
    assign bus.alu_op     = opIllegal ? OP_AND : opReg;
    assign bus.alu_a      = aReg;
    assign bus.alu_b      = bReg;
    assign bus.rsp_result = resultReg;
    assign bus.rsp_v      = vReg;
    assign bus.rsp_zero   = zeroReg;
    assign bus.rsp_err    = errReg;
endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   testsRun = 0;
    int   testsFailed = 0;

    alu_share_arbiter_if #(.WIDTH(32)) ifc ();

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // Reference ALU: combinational result plus the adder/subtractor MSB
    // overflow (the raw adder overflow is presented for non-arithmetic ops).
    logic [31:0] sumVal, diffVal;
    logic        addOvf, subOvf;
    assign sumVal  = ifc.alu_a + ifc.alu_b;
    assign diffVal = ifc.alu_a - ifc.alu_b;
    assign addOvf  = (ifc.alu_a[31] == ifc.alu_b[31]) && (sumVal[31] != ifc.alu_a[31]);
    assign subOvf  = (ifc.alu_a[31] != ifc.alu_b[31]) && (diffVal[31] != ifc.alu_a[31]);
    always_comb begin
        case (ifc.alu_op)
            3'b000:  ifc.alu_result = ifc.alu_a & ifc.alu_b;
            3'b001:  ifc.alu_result = ifc.alu_a | ifc.alu_b;
            3'b010:  ifc.alu_result = sumVal;
            3'b110:  ifc.alu_result = diffVal;
            3'b111:  ifc.alu_result = {31'd0, $signed(ifc.alu_a) < $signed(ifc.alu_b)};
            default: ifc.alu_result = 32'hBAD0BAD0;
        endcase
    end
    assign ifc.alu_v = (ifc.alu_op == 3'b110) ? subOvf : addOvf;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveReq(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            ifc.req_op0 = op; ifc.req_a0 = a; ifc.req_b0 = b;
        end else begin
            ifc.req_op1 = op; ifc.req_a1 = a; ifc.req_b1 = b;
        end
    endtask

    // One full op on a single port: accept, EXEC, RESP, response handshake.
    task automatic runOp(input string tag, input int p, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input logic expV, input logic expZero,
                         input logic expErr, input logic [2:0] expAluOp);
        logic [1:0] oneHot;
        oneHot = (p == 0) ? 2'b01 : 2'b10;
        driveReq(p, op, a, b);
        ifc.req_valid = oneHot;
        ifc.rsp_ready = 2'b00;
        #1;
        checkVal({tag, ".req_ready"}, 64'(ifc.req_ready), 64'(oneHot));
        tick();
        // Later request changes must not disturb the in-flight op.
        driveReq(p, 3'b001, 32'hDEAD0000, 32'h0000BEEF);
        ifc.req_valid = 2'b00;
        #1;
        checkVal({tag, ".exec_alu_op"}, 64'(ifc.alu_op), 64'(expAluOp));
        checkVal({tag, ".exec_alu_a"}, 64'(ifc.alu_a), 64'(a));
        checkVal({tag, ".exec_alu_b"}, 64'(ifc.alu_b), 64'(b));
        checkVal({tag, ".exec_rsp_valid"}, 64'(ifc.rsp_valid), 64'(2'b00));
        tick();
        checkVal({tag, ".rsp_valid"}, 64'(ifc.rsp_valid), 64'(oneHot));
        checkVal({tag, ".rsp_result"}, 64'(ifc.rsp_result), 64'(expRes));
        checkVal({tag, ".rsp_v"}, 64'(ifc.rsp_v), 64'(expV));
        checkVal({tag, ".rsp_zero"}, 64'(ifc.rsp_zero), 64'(expZero));
        checkVal({tag, ".rsp_err"}, 64'(ifc.rsp_err), 64'(expErr));
        checkVal({tag, ".hold_alu_a"}, 64'(ifc.alu_a), 64'(a));
        ifc.rsp_ready = oneHot;
        tick();
        ifc.rsp_ready = 2'b00;
        checkVal({tag, ".done_rsp_valid"}, 64'(ifc.rsp_valid), 64'(2'b00));
    endtask

    task automatic checkResetValues(input string tag);
        checkVal({tag, ".req_ready"}, 64'(ifc.req_ready), 64'(2'b00));
        checkVal({tag, ".rsp_valid"}, 64'(ifc.rsp_valid), 64'(2'b00));
        checkVal({tag, ".rsp_result"}, 64'(ifc.rsp_result), 64'd0);
        checkVal({tag, ".rsp_flags"}, 64'({ifc.rsp_v, ifc.rsp_zero, ifc.rsp_err}), 64'd0);
        checkVal({tag, ".alu_op"}, 64'(ifc.alu_op), 64'd0);
        checkVal({tag, ".alu_a"}, 64'(ifc.alu_a), 64'd0);
        checkVal({tag, ".alu_b"}, 64'(ifc.alu_b), 64'd0);
    endtask

    initial begin
        logic [1:0] expGrant;
        ifc.req_valid = 2'b00;
        ifc.rsp_ready = 2'b00;
        driveReq(0, 3'b000, 32'd0, 32'd0);
        driveReq(1, 3'b000, 32'd0, 32'd0);
        reset = 1'b1;
        tick();
        tick();
        checkResetValues("reset");
        reset = 1'b0;
        tick();

        runOp("add_p0", 0, 3'b010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 1'b0, 1'b0, 3'b010);
        runOp("sub_p1", 1, 3'b110, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 3'b110);
        runOp("slt_p1", 1, 3'b111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 3'b111);
        runOp("ill_p0", 0, 3'b100, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 1'b1, 3'b000);
        // ALU raises its MSB overflow here, but AND must report rsp_v = 0.
        runOp("and_p0", 0, 3'b000, 32'h7FFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 3'b000);

        // Response backpressure: port 0 stalls for 5 cycles.
        driveReq(0, 3'b001, 32'h000000F0, 32'h0000000F);
        ifc.req_valid = 2'b01;
        tick();
        ifc.req_valid = 2'b00;
        tick();
        ifc.req_valid = 2'b11;
        ifc.rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkVal($sformatf("bp%0d.rsp_valid", i), 64'(ifc.rsp_valid), 64'(2'b01));
            checkVal($sformatf("bp%0d.rsp_result", i), 64'(ifc.rsp_result), 64'hFF);
            checkVal($sformatf("bp%0d.req_ready", i), 64'(ifc.req_ready), 64'(2'b00));
            tick();
        end
        ifc.req_valid = 2'b00;
        ifc.rsp_ready = 2'b01;
        tick();
        ifc.rsp_ready = 2'b00;
        ifc.req_valid = 2'b01;
        #1;
        checkVal("bp_release.rsp_valid", 64'(ifc.rsp_valid), 64'(2'b00));
        checkVal("bp_release.idle_req_ready", 64'(ifc.req_ready), 64'(2'b01));
        ifc.req_valid = 2'b00;
        tick();

        // Reset during EXEC drops the op.
        driveReq(0, 3'b010, 32'd1, 32'd2);
        ifc.req_valid = 2'b01;
        tick();
        ifc.req_valid = 2'b00;
        #1;
        checkVal("rst_exec.alu_a", 64'(ifc.alu_a), 64'd1);
        reset = 1'b1;
        tick();
        checkResetValues("rst_exec");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkVal($sformatf("rst_drop%0d.rsp_valid", i), 64'(ifc.rsp_valid), 64'(2'b00));
        end

        // Contention straight after reset: port 0 wins first.
        driveReq(0, 3'b010, 32'd10, 32'd1);
        driveReq(1, 3'b110, 32'd10, 32'd1);
        ifc.req_valid = 2'b11;
        ifc.rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            expGrant = 2'b01;
`else
            expGrant = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            #1;
            checkVal($sformatf("rr%0d.req_ready", i), 64'(ifc.req_ready), 64'(expGrant));
            tick();
            tick();
            checkVal($sformatf("rr%0d.rsp_valid", i), 64'(ifc.rsp_valid), 64'(expGrant));
            checkVal($sformatf("rr%0d.rsp_result", i), 64'(ifc.rsp_result),
                     (expGrant == 2'b01) ? 64'd11 : 64'd9);
            tick();
        end
        ifc.req_valid = 2'b00;
        ifc.rsp_ready = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
